psum_buf_ctrl: RTL and testbench

Sequencer and arbiter for one 8-entry single-port slot buffer (`sram_w16_c`, 128-bit words). Two core-side writers share the buffer as a FIFO. One downstream consumer drains it in order. The block owns the buffer's CEN/WEN/A/D pins, keeps ring pointers and occupancy, tags each word with its source core, and hides the buffer's one-cycle read latency behind a small output queue.

---
 rtl/psum_buf_pkg.sv | 27 ++
 rtl/psum_buf_ctrl_if.sv | 48 ++++
 rtl/psum_out_fifo.sv | 64 ++++++
 rtl/psum_buf_ctrl.sv | 129 ++++++++++++
 tb/tb_psum_buf_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psum_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : psum_buf_pkg
//  Description : Shared constants and op encoding for the partial-sum slot
//                buffer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package psum_buf_pkg;

    localparam int DEPTH = 8;      // slots in the attached buffer
    localparam int AW    = 3;      // slot address width

    // One buffer operation per cycle, chosen combinationally.
    typedef enum logic [1:0] {
        OP_IDLE  = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2
    } op_e;

    // Buffer pin levels.
    localparam logic c_CEN_ON    = 1'b0;
    localparam logic c_CEN_OFF   = 1'b1;
    localparam logic c_WEN_WRITE = 1'b0;
    localparam logic c_WEN_READ  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/psum_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : psum_buf_ctrl_if
//  Description : Writer, consumer and buffer-pin bundle of psum_buf_ctrl.
//                master = the controller, slave = its environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface psum_buf_ctrl_if #(
    parameter int DW = 128
);
    import psum_buf_pkg::*;

    logic          wr0_valid;
    logic [DW-1:0] wr0_data;
    logic          wr0_ready;
    logic          wr1_valid;
    logic [DW-1:0] wr1_data;
    logic          wr1_ready;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_src;

    logic          sram_CEN;
    logic          sram_WEN;
    logic [AW-1:0] sram_A;
    logic [DW-1:0] sram_D;
    logic [DW-1:0] sram_Q;

    logic [3:0]    count;
    logic          full;
    logic          almost_full;

    modport master (
        input  wr0_valid, wr0_data, wr1_valid, wr1_data, out_ready, sram_Q,
        output wr0_ready, wr1_ready, out_valid, out_data, out_src,
               sram_CEN, sram_WEN, sram_A, sram_D, count, full, almost_full
    );

    modport slave (
        output wr0_valid, wr0_data, wr1_valid, wr1_data, out_ready, sram_Q,
        input  wr0_ready, wr1_ready, out_valid, out_data, out_src,
               sram_CEN, sram_WEN, sram_A, sram_D, count, full, almost_full
    );

endinterface
`default_nettype wire

// File: rtl/psum_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : psum_out_fifo
//  Description : Small synchronous FIFO that absorbs buffer read data so the
//                one-cycle read latency is invisible to the consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_out_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 129
) (
    input  wire logic                         clk,
    input  wire logic                         rst,
    input  wire logic                         i_push,
    input  wire logic [W-1:0]                 i_push_data,
    input  wire logic                         i_pop,
    output logic      [W-1:0]                 o_head,
    output logic      [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CW = $clog2(DEPTH + 1);

    logic [W-1:0]    r_mem [DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_pop;
    logic            w_push;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop  = i_pop && (r_count != '0);
    assign w_push = i_push && ((r_count != c_CW'(DEPTH)) || w_pop);

    // Pointer and occupancy bookkeeping; simultaneous push/pop keeps count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; occupancy alone says what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/psum_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : psum_buf_ctrl
//  Description : Two-writer round-robin arbiter and ring sequencer for an
//                8-slot single-port buffer, draining in order to one
//                consumer through a short output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module psum_buf_ctrl
    import psum_buf_pkg::*;
#(
    parameter int DW       = 128,
    parameter int OQ_DEPTH = 3
) (
    input  wire logic        CLK,
    input  wire logic        rst,
    psum_buf_ctrl_if.master  bus
);
    localparam int c_OCW = $clog2(OQ_DEPTH + 1);

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [3:0]       r_count;
    logic [DEPTH-1:0] r_src_tag;
    logic             r_rr;
    logic             r_rd_inflight;
    logic             r_inflight_tag;

    op_e              w_op;
    logic             w_grant;
    logic [c_OCW-1:0] w_oq_count;
    logic [c_OCW:0]   w_reserved;
    logic [DW:0]      w_oq_head;
    logic             w_out_valid;

    // Op selection: reads win while the output queue has credit, so the
    // consumer never stalls on a non-empty buffer; writes fill the gaps.
    always_comb begin
        w_reserved = {1'b0, w_oq_count} + {{c_OCW{1'b0}}, r_rd_inflight};
        w_grant    = (bus.wr0_valid && bus.wr1_valid) ? r_rr : bus.wr1_valid;
        w_op       = OP_IDLE;
        if (rst) begin
            w_op = OP_IDLE;
        end else if ((r_count != 4'd0) && (w_reserved < (c_OCW+1)'(OQ_DEPTH))) begin
            w_op = OP_READ;
        end else if ((r_count < 4'(DEPTH)) && (bus.wr0_valid || bus.wr1_valid)) begin
            w_op = OP_WRITE;
        end
    end

    // Buffer pins and write grants follow directly from the chosen op.
    always_comb begin
        bus.sram_CEN  = c_CEN_OFF;
        bus.sram_WEN  = c_WEN_READ;
        bus.sram_A    = '0;
        bus.sram_D    = '0;
        bus.wr0_ready = 1'b0;
        bus.wr1_ready = 1'b0;
        case (w_op)
            OP_WRITE: begin
                bus.sram_CEN  = c_CEN_ON;
                bus.sram_WEN  = c_WEN_WRITE;
                bus.sram_A    = r_wr_ptr;
                bus.sram_D    = w_grant ? bus.wr1_data : bus.wr0_data;
                bus.wr0_ready = !w_grant;
                bus.wr1_ready = w_grant;
            end
            OP_READ: begin
                bus.sram_CEN = c_CEN_ON;
                bus.sram_WEN = c_WEN_READ;
                bus.sram_A   = r_rd_ptr;
            end
            default: ;
        endcase
    end

    // Ring pointers, occupancy, per-slot source tags and read-in-flight flag.
    always_ff @(posedge CLK) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_src_tag      <= '0;
            r_rr           <= 1'b0;
            r_rd_inflight  <= 1'b0;
            r_inflight_tag <= 1'b0;
        end else begin
            r_rd_inflight <= (w_op == OP_READ);
            case (w_op)
                OP_WRITE: begin
                    r_src_tag[r_wr_ptr] <= w_grant;
                    r_wr_ptr            <= r_wr_ptr + 1'b1;
                    r_count             <= r_count + 4'd1;
                    r_rr                <= ~w_grant;
                end
                OP_READ: begin
                    r_inflight_tag <= r_src_tag[r_rd_ptr];
                    r_rd_ptr       <= r_rd_ptr + 1'b1;
                    r_count        <= r_count - 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Read data arrives one cycle after issue and is queued with its tag.
    psum_out_fifo #(
        .DEPTH (OQ_DEPTH),
        .W     (DW + 1)
    ) u_out_fifo (
        .clk         (CLK),
        .rst         (rst),
        .i_push      (r_rd_inflight),
        .i_push_data ({r_inflight_tag, bus.sram_Q}),
        .i_pop       (w_out_valid && bus.out_ready),
        .o_head      (w_oq_head),
        .o_count     (w_oq_count)
    );

    assign w_out_valid     = (w_oq_count != '0);
    assign bus.out_valid   = w_out_valid;
    assign bus.out_data    = w_out_valid ? w_oq_head[DW-1:0] : '0;
    assign bus.out_src     = w_out_valid ? w_oq_head[DW] : 1'b0;
    assign bus.count       = r_count;
    assign bus.full        = (r_count == 4'd8);
    assign bus.almost_full = (r_count == 4'd7);

endmodule
`default_nettype wire

// File: tb/tb_psum_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_psum_buf_ctrl
//  Description : Directed bench for psum_buf_ctrl with a behavioural model of
//                the 8x128 single-port slot buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_psum_buf_ctrl;
    localparam int DW = 128;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    psum_buf_ctrl_if #(.DW(DW)) bus ();

    psum_buf_ctrl #(.DW(DW), .OQ_DEPTH(3)) dut (
        .CLK (CLK),
        .rst (rst),
        .bus (bus)
    );

    // Buffer model: write when WEN=0, registered read data when WEN=1.
    logic [DW-1:0] mem [8];
    always_ff @(posedge CLK) begin
        if (rst) begin
            bus.sram_Q <= '0;
        end else if (!bus.sram_CEN) begin
            if (!bus.sram_WEN) mem[bus.sram_A] <= bus.sram_D;
            else               bus.sram_Q      <= mem[bus.sram_A];
        end
    end

    int          errors = 0;
    int          checks = 0;
    int          n_acc  = 0;
    logic [DW:0] exp_q [$];

    function automatic logic [DW-1:0] mkdata(input logic core, input int n);
        return {16'hC0DE, 15'h0, core, 32'(n) ^ 32'h5A5A_0000, 32'hFFFF_FFFF - 32'(n), 32'(n)};
    endfunction

    task automatic set_in(input logic v0, input logic v1, input logic rdy);
        bus.wr0_valid = v0;
        bus.wr1_valid = v1;
        bus.out_ready = rdy;
        bus.wr0_data  = mkdata(1'b0, n_acc);
        bus.wr1_data  = mkdata(1'b1, n_acc);
    endtask

    // Records accepted writes into the expected queue; reports a pop.
    task automatic observe(output bit popped, output logic [DW:0] word);
        if (bus.wr0_valid && bus.wr0_ready) begin
            exp_q.push_back({1'b0, bus.wr0_data});
            n_acc++;
        end
        if (bus.wr1_valid && bus.wr1_ready) begin
            exp_q.push_back({1'b1, bus.wr1_data});
            n_acc++;
        end
        popped = bus.out_valid && bus.out_ready;
        word   = {bus.out_src, bus.out_data};
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        #1 rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_in(1'b1, 1'b1, 1'b0);
        @(posedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        checks++; if (bus.wr0_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready0: got %b expected 0", bus.wr0_ready); end
        checks++; if (bus.wr1_ready !== 1'b0) begin errors++; $display("FAIL rst_hold_ready1: got %b expected 0", bus.wr1_ready); end
        checks++; if (bus.sram_CEN !== 1'b1) begin errors++; $display("FAIL rst_hold_cen: got %b expected 1", bus.sram_CEN); end
        @(posedge CLK);
        #1 rst = 1'b0;
        set_in(1'b0, 1'b0, 1'b0);
        exp_q.delete();
        @(negedge CLK);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", bus.count); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %b expected 0", bus.full); end
        checks++; if (bus.almost_full !== 1'b0) begin errors++; $display("FAIL rst_afull: got %b expected 0", bus.almost_full); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL rst_out_data: got %0h expected 0", bus.out_data); end
        checks++; if (bus.out_src !== 1'b0) begin errors++; $display("FAIL rst_out_src: got %b expected 0", bus.out_src); end
        checks++; if ({bus.sram_CEN, bus.sram_WEN} !== 2'b11) begin errors++; $display("FAIL rst_cen_wen: got %b expected 11", {bus.sram_CEN, bus.sram_WEN}); end
        checks++; if (bus.sram_A !== 3'd0) begin errors++; $display("FAIL rst_addr: got %0d expected 0", bus.sram_A); end
        checks++; if (bus.sram_D !== '0) begin errors++; $display("FAIL rst_wdata: got %0h expected 0", bus.sram_D); end
    endtask

    // One word: write at t, read at t+1, visible on the output at t+3.
    task automatic test_latency();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        apply_reset();
        @(posedge CLK); #1 set_in(1'b1, 1'b0, 1'b0);
        @(negedge CLK); observe(p, w);
        checks++; if (bus.wr0_ready !== 1'b1) begin errors++; $display("FAIL lat_grant: got %b expected 1", bus.wr0_ready); end
        checks++; if ({bus.sram_CEN, bus.sram_WEN, bus.sram_A} !== 5'b00_000) begin errors++; $display("FAIL lat_write_op: got %b expected 00000", {bus.sram_CEN, bus.sram_WEN, bus.sram_A}); end
        @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b0);
        @(negedge CLK); observe(p, w);
        checks++; if ({bus.sram_CEN, bus.sram_WEN, bus.sram_A} !== 5'b01_000) begin errors++; $display("FAIL lat_read_op: got %b expected 01000", {bus.sram_CEN, bus.sram_WEN, bus.sram_A}); end
        checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL lat_count: got %0d expected 1", bus.count); end
        @(posedge CLK); #1;
        @(negedge CLK); observe(p, w);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", bus.out_valid); end
        @(posedge CLK); #1;
        @(negedge CLK); observe(p, w);
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        checks++; if (bus.out_valid !== 1'b1 || w !== e) begin errors++; $display("FAIL lat_output: got valid=%b %0h expected valid=1 %0h", bus.out_valid, w, e); end
        @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b1);
        @(negedge CLK); observe(p, w);
        @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL lat_after_pop: got %b expected 0", bus.out_valid); end
        exp_q.delete();
    endtask

    task automatic test_single_writer();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        int          base;
        int          peak;
        int          af_seen;
        int          got;
        apply_reset();
        base = n_acc; peak = 0; af_seen = 0; got = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1 set_in((n_acc - base) < 8, 1'b0, 1'b0);
            @(negedge CLK); observe(p, w);
            if (int'(bus.count) > peak) peak = int'(bus.count);
            if (bus.almost_full) af_seen++;
        end
        checks++; if (n_acc - base != 8) begin errors++; $display("FAIL sw_accepted: got %0d expected 8", n_acc - base); end
        checks++; if (peak != 5) begin errors++; $display("FAIL sw_peak_count: got %0d expected 5", peak); end
        checks++; if (af_seen != 0) begin errors++; $display("FAIL sw_afull_cycles: got %0d expected 0", af_seen); end
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL sw_count: got %0d expected 5", bus.count); end
        for (int c = 0; c < 40 && got < 8; c++) begin
            @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b1);
            @(negedge CLK); observe(p, w);
            if (p) begin
                e = {1'b0, mkdata(1'b0, base + got)};
                checks++; if (w !== e) begin errors++; $display("FAIL sw_data[%0d]: got %0h expected %0h", got, w, e); end
                got++;
            end
        end
        checks++; if (got != 8) begin errors++; $display("FAIL sw_drained: got %0d expected 8", got); end
        exp_q.delete();
    endtask

    // Leaves the buffer full (8 slots) with 3 words in the output queue.
    task automatic test_both_writers();
        bit          p;
        logic [DW:0] w;
        logic        last;
        logic        g;
        int          grants;
        int          af_cnt;
        apply_reset();
        last = 1'b1; grants = 0; af_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge CLK); #1 set_in(1'b1, 1'b1, 1'b0);
            @(negedge CLK);
            if (bus.wr0_ready && bus.wr1_ready) begin errors++; checks++; $display("FAIL bw_double_grant: got 11 expected one-hot"); end
            if (bus.wr0_ready || bus.wr1_ready) begin
                g = bus.wr1_ready;
                checks++; if (g === last) begin errors++; $display("FAIL bw_alternate[%0d]: got %b expected %b", grants, g, ~last); end
                if (bus.full) begin errors++; checks++; $display("FAIL bw_grant_when_full: got grant expected none"); end
                last = g;
                grants++;
            end
            if (bus.almost_full) af_cnt++;
            observe(p, w);
        end
        checks++; if (grants != 11) begin errors++; $display("FAIL bw_grants: got %0d expected 11", grants); end
        checks++; if (af_cnt != 1) begin errors++; $display("FAIL bw_afull_cycles: got %0d expected 1", af_cnt); end
        checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL bw_count: got %0d expected 8", bus.count); end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL bw_full: got %b expected 1", bus.full); end
        checks++; if ({bus.wr0_ready, bus.wr1_ready} !== 2'b00) begin errors++; $display("FAIL bw_ready_full: got %b expected 00", {bus.wr0_ready, bus.wr1_ready}); end
    endtask

    task automatic test_drain_full();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        int          pops;
        int          first_rd;
        int          lat;
        pops = 0; first_rd = -1; lat = -1;
        for (int c = 0; c < 30 && pops < 11; c++) begin
            @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b1);
            @(negedge CLK);
            if (first_rd < 0 && !bus.sram_CEN && bus.sram_WEN) first_rd = c;
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_rate[%0d]: got %b expected 1", c, bus.out_valid); end
            observe(p, w);
            if (p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (w !== e) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", pops, w, e); end
                checks++; if (w[DW] !== 1'(pops % 2)) begin errors++; $display("FAIL drain_src[%0d]: got %b expected %0d", pops, w[DW], pops % 2); end
                if (pops == 3) lat = c - first_rd;
                pops++;
            end
        end
        checks++; if (pops != 11) begin errors++; $display("FAIL drain_pops: got %0d expected 11", pops); end
        checks++; if (first_rd != 1) begin errors++; $display("FAIL drain_first_read: got %0d expected 1", first_rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL drain_latency: got %0d expected 2", lat); end
        checks++; if (bus.count !== 4'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL drain_empty: got count=%0d full=%b expected 0 0", bus.count, bus.full); end
    endtask

    task automatic test_wrap();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        int          base;
        int          n;
        int          wa;
        int          ra;
        int          pops;
        apply_reset();
        base = n_acc; wa = 0; ra = 0; pops = 0;
        for (int c = 0; c < 200 && pops < 20; c++) begin
            n = n_acc - base;
            @(posedge CLK); #1 set_in(n < 20 && (n % 2) == 0, n < 20 && (n % 2) == 1, 1'b1);
            @(negedge CLK);
            if (!bus.sram_CEN) begin
                if (!bus.sram_WEN) begin
                    checks++; if (bus.sram_A !== 3'(wa % 8)) begin errors++; $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", wa, bus.sram_A, wa % 8); end
                    wa++;
                end else begin
                    checks++; if (bus.sram_A !== 3'(ra % 8)) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %0d expected %0d", ra, bus.sram_A, ra % 8); end
                    ra++;
                end
            end
            observe(p, w);
            if (p) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (w !== e) begin errors++; $display("FAIL wrap_data[%0d]: got %0h expected %0h", pops, w, e); end
                pops++;
            end
        end
        checks++; if (pops != 20 || wa != 20 || ra != 20) begin errors++; $display("FAIL wrap_totals: got pops=%0d wr=%0d rd=%0d expected 20 20 20", pops, wa, ra); end
    endtask

    task automatic test_backpressure();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        int          base;
        int          n;
        int          outst;
        int          pops;
        apply_reset();
        base = n_acc; outst = 0; pops = 0;
        for (int c = 0; c < 600 && pops < 30; c++) begin
            n = n_acc - base;
            @(posedge CLK);
            #1 set_in(n < 30 && $urandom_range(0, 1) == 1, n < 30 && $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
            @(negedge CLK);
            if (!bus.sram_CEN && bus.sram_WEN) outst++;
            observe(p, w);
            if (p) begin
                outst--;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                checks++; if (w !== e) begin errors++; $display("FAIL bp_data[%0d]: got %0h expected %0h", pops, w, e); end
                pops++;
            end
            if (outst > 3) begin errors++; checks++; $display("FAIL bp_reserved: got %0d expected <=3", outst); end
        end
        checks++; if (pops != 30 || exp_q.size() != 0) begin errors++; $display("FAIL bp_totals: got pops=%0d left=%0d expected 30 0", pops, exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit          p;
        logic [DW:0] w;
        logic [DW:0] e;
        int          base;
        int          got;
        apply_reset();
        base = n_acc; got = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge CLK); #1 set_in((n_acc - base) < 9, 1'b0, 1'b0);
            @(negedge CLK); observe(p, w);
        end
        checks++; if (bus.count !== 4'd6) begin errors++; $display("FAIL rm_fill_count: got %0d expected 6", bus.count); end
        @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b1);
        @(negedge CLK); observe(p, w);
        @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if ({bus.sram_CEN, bus.sram_WEN} !== 2'b01) begin errors++; $display("FAIL rm_read_issue: got %b expected 01", {bus.sram_CEN, bus.sram_WEN}); end
        @(posedge CLK); #1 rst = 1'b1;
        @(negedge CLK);
        checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL rm_pre_count: got %0d expected 5", bus.count); end
        @(posedge CLK); #1 rst = 1'b0;
        exp_q.delete();
        @(negedge CLK);
        checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", bus.count); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rm_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.sram_CEN !== 1'b1) begin errors++; $display("FAIL rm_cen: got %b expected 1", bus.sram_CEN); end
        @(posedge CLK); #1 set_in(1'b1, 1'b0, 1'b0);
        @(negedge CLK);
        checks++; if ({bus.wr0_ready, bus.sram_WEN, bus.sram_A} !== 5'b1_0_000) begin errors++; $display("FAIL rm_write_addr: got %b expected 10000", {bus.wr0_ready, bus.sram_WEN, bus.sram_A}); end
        observe(p, w);
        for (int c = 0; c < 10 && got < 1; c++) begin
            @(posedge CLK); #1 set_in(1'b0, 1'b0, 1'b1);
            @(negedge CLK); observe(p, w);
            if (p) begin
                e = {1'b0, mkdata(1'b0, n_acc - 1)};
                checks++; if (w !== e) begin errors++; $display("FAIL rm_data: got %0h expected %0h", w, e); end
                got++;
            end
        end
        checks++; if (got != 1) begin errors++; $display("FAIL rm_drained: got %0d expected 1", got); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_single_writer();
        test_both_writers();
        test_drain_full();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
